// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit MIPS core: default widths, reset PC and
// the fetch-stage state encoding.
package mips8_pkg;

    localparam int         DEF_ADDR_W   = 8;
    localparam int         DEF_INSTR_W  = 8;
    localparam logic [7:0] DEF_RESET_PC = 8'h00;
    localparam int         STAT_W       = 16;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC arithmetic for the fetch stage: sequential increment and jump
// target, both wrapping modulo 2^ADDR_W.
module fetch_pc_next #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] jump_pc,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [ADDR_W-1:0] jump_target
);

    assign pc_inc      = pc + ADDR_W'(1);
    // jump_addr is already sign-extended, so a plain wrapping add handles negative offsets.
    assign jump_target = jump_pc + ADDR_W'(1) + jump_addr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests instruction memory and
// hands words to decode. Define FETCH_STATS_EN to add fetch/redirect counters.
module fetch_unit
    import mips8_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_pc,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output fetch_state_e       dbg_state
`ifdef FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0]  fetch_count,
    output logic [STAT_W-1:0]  redirect_count
`endif
);

    // Handshakes: a memory transfer completes on a cycle with imem_req & imem_ready;
    // a decode transfer completes on instr_valid & instr_ready. Producers hold
    // their request/valid and payload stable until the transfer completes.

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               kill_q, kill_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jump_target;

    fetch_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc          (pc_q),
        .jump_pc     (jump_pc),
        .jump_addr   (jump_addr),
        .pc_inc      (pc_inc),
        .jump_target (jump_target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        tgt_d      = tgt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (jump_valid) begin
                        pc_d   = jump_target;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        pc_d   = tgt_q;
                        kill_d = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end else if (jump_valid) begin
                    // The in-flight request cannot be withdrawn: park the target
                    // and keep the address steady until memory answers.
                    kill_d = 1'b1;
                    tgt_d  = jump_target;
                end
            end
            HOLD: begin
                if (jump_valid) begin
                    pc_d    = jump_target;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            tgt_q      <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            tgt_q      <= tgt_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Gating with rst_n keeps the request low for the whole reset window.
    assign imem_req    = rst_n && (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign dbg_state   = state_q;

`ifdef FETCH_STATS_EN
    logic              accept;
    logic [STAT_W-1:0] fetch_count_q, fetch_count_d;
    logic [STAT_W-1:0] redirect_count_q, redirect_count_d;

    assign accept = (state_q == HOLD) && instr_ready;

    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (accept && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + STAT_W'(1);
        end
        if (jump_valid && (redirect_count_q != '1)) begin
            redirect_count_d = redirect_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a fixed vector table for the zero-wait
// stream and stall, directed redirect/wrap/reset sequences, then random traffic.
module tb_fetch_unit;
    import mips8_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         jump_valid = 1'b0;
    logic [7:0]   jump_pc = 8'h00;
    logic [7:0]   jump_addr = 8'h00;
    logic         imem_req;
    logic [7:0]   imem_addr;
    logic         imem_ready = 1'b0;
    logic [7:0]   imem_rdata = 8'h00;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic [7:0]   instr;
    logic [7:0]   instr_pc;
    fetch_state_e dbg_state;
`ifdef FETCH_STATS_EN
    logic [15:0]  fetch_count;
    logic [15:0]  redirect_count;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .jump_valid  (jump_valid),
        .jump_pc     (jump_pc),
        .jump_addr   (jump_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .dbg_state   (dbg_state)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory image, next PC decode should see, counts.
    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] exp_pc;
    int         mem_lat;
    int         mem_cnt;
    int         n_accept;
    int         n_jump;
    logic       prev_pending;
    logic [7:0] prev_addr;

    typedef struct {
        logic       rdy;
        logic [7:0] rdata;
        logic       ir;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_instr;
        logic [7:0] e_ipc;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] redirect_target(input logic [7:0] jpc, input logic [7:0] ja);
        int t;
        t = int'(jpc) + 1 + int'($signed(ja));
        return 8'(t & 255);
    endfunction

    task automatic setv(input int i, input logic rdy, input logic [7:0] rdata, input logic ir,
                        input logic e_req, input logic [7:0] e_addr, input logic e_valid,
                        input logic [7:0] e_instr, input logic [7:0] e_ipc);
        tbl[i] = '{rdy, rdata, ir, e_req, e_addr, e_valid, e_instr, e_ipc};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        imem_ready  = 1'b1;
        imem_rdata  = 8'h5A;
        jump_valid  = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 8'h00);
        chk("rst_instr_pc", instr_pc, 8'h00);
`ifdef FETCH_STATS_EN
        chk("rst_fetch_count", fetch_count, 16'h0);
        chk("rst_redirect_count", redirect_count, 16'h0);
`endif
        repeat (2) @(negedge clk);
        chk("rst_hold_valid", instr_valid, 1'b0);
        rst_n        = 1'b1;
        imem_ready   = 1'b0;
        mem_cnt      = 0;
        prev_pending = 1'b0;
        exp_pc       = 8'h00;
        n_accept     = 0;
        n_jump       = 0;
        exp_q.delete();
        #1;
        chk("rel_req", imem_req, 1'b1);
        chk("rel_addr", imem_addr, 8'h00);
    endtask

    task automatic sample();
        @(negedge clk);
        if (instr_valid) chk("model_instr_pc", instr_pc, exp_pc);
        if (prev_pending && imem_req) chk("addr_stable", imem_addr, prev_addr);
    endtask

    task automatic drive(input logic jv, input logic [7:0] jpc, input logic [7:0] ja, input logic ir);
        if (imem_req) begin
            if (mem_cnt >= mem_lat) begin
                imem_ready = 1'b1;
                imem_rdata = mem[imem_addr];
                mem_cnt    = 0;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = 8'($urandom);
                mem_cnt++;
            end
        end else begin
            imem_ready = 1'b0;
            mem_cnt    = 0;
        end
        prev_pending = imem_req && !imem_ready;
        prev_addr    = imem_addr;
        jump_valid   = jv;
        jump_pc      = jpc;
        jump_addr    = ja;
        instr_ready  = ir;
        if (instr_valid && ir) begin
            exp_q.push_back(mem[exp_pc]);
            chk("accept_word", instr, exp_q.pop_front());
            n_accept++;
            exp_pc = exp_pc + 8'd1;
        end
        if (jv) begin
            exp_pc = redirect_target(jpc, ja);
            n_jump++;
        end
    endtask

    // Leaves the bench at a sampled point; the caller must drive next.
    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (instr_valid) begin
                seen = 1'b1;
                break;
            end
            drive(1'b0, 8'h00, 8'h00, 1'b0);
        end
        chk({name, "_valid_seen"}, seen, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit moved;
        int acc0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem_lat = 0;

        // Zero-wait stream A0..A5, then a 4-cycle decode stall at pc 5.
        setv(0,  1, 8'hA0, 1, 1, 8'h00, 0, 8'h00, 8'h00);
        setv(1,  0, 8'h00, 1, 0, 8'h00, 1, 8'hA0, 8'h00);
        setv(2,  1, 8'hA1, 1, 1, 8'h01, 0, 8'h00, 8'h00);
        setv(3,  0, 8'h00, 1, 0, 8'h00, 1, 8'hA1, 8'h01);
        setv(4,  1, 8'hA2, 1, 1, 8'h02, 0, 8'h00, 8'h00);
        setv(5,  0, 8'h00, 1, 0, 8'h00, 1, 8'hA2, 8'h02);
        setv(6,  1, 8'hA3, 1, 1, 8'h03, 0, 8'h00, 8'h00);
        setv(7,  0, 8'h00, 1, 0, 8'h00, 1, 8'hA3, 8'h03);
        setv(8,  1, 8'hA4, 1, 1, 8'h04, 0, 8'h00, 8'h00);
        setv(9,  0, 8'h00, 1, 0, 8'h00, 1, 8'hA4, 8'h04);
        setv(10, 1, 8'hA5, 1, 1, 8'h05, 0, 8'h00, 8'h00);
        setv(11, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 8'h05);
        setv(12, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 8'h05);
        setv(13, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 8'h05);
        setv(14, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 8'h05);
        setv(15, 0, 8'h00, 1, 0, 8'h00, 1, 8'hA5, 8'h05);
        setv(16, 0, 8'h00, 0, 1, 8'h06, 0, 8'h00, 8'h00);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
            if (tbl[i].e_valid || i == 0) begin
                chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
                chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
            end
            imem_ready  = tbl[i].rdy;
            imem_rdata  = tbl[i].rdata;
            instr_ready = tbl[i].ir;
        end

        // Redirect while a slow request to 8'h11 is outstanding.
        do_reset();
        sample();
        drive(1'b1, 8'h0F, 8'h01, 1'b0);
        mem_lat = 3;
        sample();
        chk("seq3_addr_11", imem_addr, 8'h11);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        sample();
        drive(1'b1, 8'h10, 8'hFC, 1'b0);
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            chk("seq3_no_stale_valid", instr_valid, 1'b0);
            if (imem_addr != 8'h11) begin
                moved = 1'b1;
                break;
            end
            drive(1'b0, 8'h00, 8'h00, 1'b0);
        end
        chk("seq3_reissued", moved, 1'b1);
        chk("seq3_addr_0d", imem_addr, 8'h0D);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        wait_valid("seq3");
        chk("seq3_instr_pc", instr_pc, 8'h0D);

        // Redirect from HOLD at 8'hFE with a wrapping positive offset.
        mem_lat = 0;
        drive(1'b1, 8'hFD, 8'h00, 1'b0);
        wait_valid("seq4a");
        chk("seq4_hold_pc", instr_pc, 8'hFE);
        drive(1'b1, 8'hFE, 8'h03, 1'b0);
        sample();
        chk("seq4_valid_drop", instr_valid, 1'b0);
        chk("seq4_req", imem_req, 1'b1);
        chk("seq4_addr_02", imem_addr, 8'h02);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        wait_valid("seq4b");
        chk("seq4_instr_pc", instr_pc, 8'h02);

        // Accepting 8'hFF wraps the next fetch to 8'h00.
        drive(1'b1, 8'hFE, 8'h00, 1'b0);
        wait_valid("seq5");
        chk("seq5_pc_ff", instr_pc, 8'hFF);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        sample();
        chk("seq5_req", imem_req, 1'b1);
        chk("seq5_addr_00", imem_addr, 8'h00);

        // Reset while a slow request is pending.
        mem_lat = 6;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        sample();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        do_reset();
        mem_lat = 0;
        wait_valid("seq6");
        chk("seq6_restart_pc", instr_pc, 8'h00);
        drive(1'b0, 8'h00, 8'h00, 1'b1);

        // Random traffic against the model, several memory latencies.
        do_reset();
        for (int lat = 0; lat < 4; lat++) begin
            mem_lat = lat;
            acc0 = n_accept;
            for (int c = 0; c < 400; c++) begin
                sample();
                drive(($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom),
                      ($urandom_range(0, 3) != 0));
            end
            chk($sformatf("rand_lat%0d_progress", lat), (n_accept - acc0) > 20, 1'b1);
        end
        sample();
`ifdef FETCH_STATS_EN
        chk("stats_fetch_count", fetch_count, n_accept);
        chk("stats_redirect_count", redirect_count, n_jump);
`endif
        drive(1'b0, 8'h00, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 8-bit MIPS core: owns the program counter, issues requests to instruction memory over a req/ready handshake, and presents each fetched instruction to decode over a valid/ready handshake. It sits directly upstream of decode and consumes the 8-bit sign-extended jump offset produced by the jump-field extender, redirecting the PC when a jump resolves.

## Interface
- `ADDR_W`, 8, PC and instruction-memory address width
- `INSTR_W`, 8, instruction width
- `RESET_PC`, 8'h00, PC value after reset
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `jump_valid`  in  1  one-cycle pulse: jump resolved this cycle
- `jump_pc`  in  ADDR_W  PC of the jump instruction
- `jump_addr`  in  ADDR_W  sign-extended signed offset from jump extender
- `imem_req`  out  1  fetch request, held until `imem_ready`
- `imem_addr`  out  ADDR_W  fetch address, stable while `imem_req`
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_W  instruction word
- `instr_valid`  out  1  `instr`/`instr_pc` hold a live instruction
- `instr_ready`  in  1  decode accepts this cycle
- `instr`  out  INSTR_W  fetched instruction
- `instr_pc`  out  ADDR_W  address of `instr`

## Operation
- States: FETCH (request outstanding), HOLD (instruction presented). Reset enters FETCH.
- FETCH: `imem_req`=1, `imem_addr`=pc. On `imem_ready`: if kill flag clear, latch `imem_rdata` into `instr`, pc into `instr_pc`, go HOLD; if kill set, discard data, clear kill, stay FETCH at current (redirected) pc.
- HOLD: `instr_valid`=1, `imem_req`=0. On `instr_valid & instr_ready`: pc <= pc+1, go FETCH.
- Redirect: on `jump_valid`, target = `jump_pc` + 1 + `jump_addr`, modulo 2^ADDR_W (wraps 8'hFF+1 -> 8'h00; negative offsets wrap downward). pc <= target.
  - In FETCH without `imem_ready`: request cannot be aborted; set kill, keep `imem_addr` at old pc until ready, then reissue at target.
  - In FETCH with `imem_ready` same cycle: returning data discarded, stay FETCH at target.
  - In HOLD: drop `instr_valid` next cycle, go FETCH at target. If `instr_ready` also high that cycle, that instruction counts as accepted; redirect still wins for pc.
- PC increment wraps 8'hFF -> 8'h00.
- `jump_valid` in consecutive cycles: last one wins.

## Timing
- Reset values: pc=`RESET_PC`, state=FETCH, kill=0, `imem_req`=0 during reset, 1 in first cycle after release; `instr_valid`=0, `instr`=0, `instr_pc`=0.
- `imem_req`/`imem_addr` are registered-state decoded; no combinational path from `instr_ready` or `jump_valid` to `imem_addr` (address change visible the cycle after redirect).
- Zero-wait memory (`imem_ready` with request): `instr_valid` one cycle after request; peak throughput one instruction per 2 cycles.
- Redirect to first new request: 1 cycle if no request outstanding; otherwise until pending `imem_ready` plus 1.
- `instr`/`instr_pc` stable while `instr_valid` & !`instr_ready`.
- Reset asserted mid-fetch: everything returns to reset values immediately; any later `imem_ready` for the abandoned request is ignored since `imem_req` is low.

## Configuration
- `FETCH_STATS_EN` defined: adds outputs `fetch_count` (16-bit, increments per accepted instruction) and `redirect_count` (16-bit, increments per `jump_valid`), both saturating at 16'hFFFF, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package `mips8_pkg`: `ADDR_W`/`INSTR_W` defaults, fetch state enum (FETCH, HOLD), `RESET_PC` default.
- One sub-module: `fetch_pc_next`, combinational, computes redirect target and pc+1 with wrap.

## Test plan
- Reset release, zero-wait memory returning 8'hA0..8'hA3, `instr_ready`=1 -> `imem_addr` 0,1,2,3; `instr_pc` 0..3 with matching `instr`, one per 2 cycles.
- `instr_ready` low 4 cycles while HOLD at pc 5 -> `instr`/`instr_pc`=5 stable, `imem_req`=0, no pc advance.
- Memory 3-cycle latency, `jump_valid` with `jump_pc`=8'h10, `jump_addr`=8'hFC while request to 8'h11 pending -> returned word discarded, next request at 8'h0D.
- `jump_valid` in HOLD at pc 8'hFE, `jump_pc`=8'hFE, `jump_addr`=8'h03 -> `instr_valid` drops, next request at 8'h02.
- pc 8'hFF accepted -> next `imem_addr` 8'h00.
- Assert `rst_n` low during pending request -> `imem_req`, `instr_valid` 0 immediately; restart at `RESET_PC`; with `FETCH_STATS_EN`, counters read 0.
